// File: rtl/kong_pkg.sv
// Shared encodings for the kong controller: top FSM states, animation phases
// and the LFSR seed/taps used by the random source.
`default_nettype none

package kong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAYING = 2'b01,
        ST_PAUSED  = 2'b10
    } top_state_e;

    typedef enum logic [1:0] {
        AN_NORMAL = 2'b00,
        AN_GET    = 2'b01,
        AN_HOLD   = 2'b10,
        AN_DROP   = 2'b11
    } anim_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Maximal-length Galois taps (x^16+x^14+x^13+x^11+1); nonzero seed never reaches zero.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/kong_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; exposes its low OUT_W bits as the random value.
`default_nettype none

module lfsr16
    import kong_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [OUT_W-1:0] rnd_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);
    assign rnd_o  = lfsr_q[OUT_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kong_ctrl.sv
// Donkey-Kong style barrel thrower: top game FSM plus a timed animation
// sequencer that issues barrel drop requests and tracks barrels in flight.
`default_nettype none

module kong_ctrl
    import kong_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int NORMAL_LEN = 160,
    parameter int GET_LEN    = 32,
    parameter int HOLD_LEN   = 32,
    parameter int JITTER_W   = 4,
    parameter int MAX_LIVE   = 4,
    parameter int INIT_X     = 127,
    parameter int INIT_Y     = 79,
    localparam int LW        = $clog2(MAX_LIVE + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          over_i,
    input  logic          pause_i,
    input  logic          drop_ack_i,
    input  logic          barrel_gone_i,
    output logic          drop_req_o,
    output logic [9:0]    x_o,
    output logic [8:0]    y_o,
    output logic [1:0]    state_o,
    output logic [1:0]    animation_state_o,
    output logic [LW-1:0] live_count_o
);

    localparam int RND_W = (JITTER_W > 0) ? JITTER_W : 1;

    top_state_e       state_q, state_d;
    anim_e            anim_q, anim_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [LW-1:0]    live_q, live_d;
    logic             drop_req_q, drop_req_d;

    logic [RND_W-1:0] rnd;
    logic [CNT_W-1:0] jitter;
    logic [CNT_W-1:0] normal_reload;
    logic             ack_fire;
    logic             gone_fire;

    lfsr16 #(
        .OUT_W (RND_W)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rnd_o  (rnd)
    );

    generate
        if (JITTER_W > 0) begin : g_jitter
            assign jitter = CNT_W'(rnd);
        end else begin : g_no_jitter
            assign jitter = CNT_W'(rnd & 1'b0);
        end
    endgenerate

    assign normal_reload = CNT_W'(NORMAL_LEN - 1) + jitter;

    // drop_req_q is only ever high while PLAYING in DROP, so it gates acks during pause.
    assign ack_fire  = (state_q == ST_PLAYING) && (anim_q == AN_DROP) && drop_req_q && drop_ack_i;
    assign gone_fire = (state_q != ST_IDLE) && barrel_gone_i;

    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        timer_d = timer_q;
        live_d  = live_q;

        case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_PLAYING;
            ST_PLAYING: begin
                if (over_i)       state_d = ST_IDLE;
                else if (pause_i) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (over_i)        state_d = ST_IDLE;
                else if (!pause_i) state_d = ST_PLAYING;
            end
            default:    state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            anim_d  = AN_NORMAL;
            timer_d = normal_reload;
            live_d  = '0;
        end else begin
            if (state_q == ST_PLAYING) begin
                case (anim_q)
                    AN_NORMAL: begin
                        if (timer_q != '0) begin
                            timer_d = timer_q - CNT_W'(1);
                        end else if (live_q < LW'(MAX_LIVE)) begin
                            anim_d  = AN_GET;
                            timer_d = CNT_W'(GET_LEN - 1);
                        end
                    end
                    AN_GET: begin
                        if (timer_q != '0) begin
                            timer_d = timer_q - CNT_W'(1);
                        end else begin
                            anim_d  = AN_HOLD;
                            timer_d = CNT_W'(HOLD_LEN - 1);
                        end
                    end
                    AN_HOLD: begin
                        if (timer_q != '0) begin
                            timer_d = timer_q - CNT_W'(1);
                        end else begin
                            anim_d  = AN_DROP;
                            timer_d = '0;
                        end
                    end
                    AN_DROP: begin
                        if (ack_fire) begin
                            anim_d  = AN_NORMAL;
                            timer_d = normal_reload;
                        end
                    end
                    default: anim_d = AN_NORMAL;
                endcase
            end

            // A spawn and a departure in the same cycle cancel out.
            if (ack_fire && !gone_fire) begin
                live_d = live_q + LW'(1);
            end else if (gone_fire && !ack_fire && live_q != '0) begin
                live_d = live_q - LW'(1);
            end
        end

        drop_req_d = (state_d == ST_PLAYING) && (anim_d == AN_DROP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            anim_q     <= AN_NORMAL;
            timer_q    <= '0;
            live_q     <= '0;
            drop_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            anim_q     <= anim_d;
            timer_q    <= timer_d;
            live_q     <= live_d;
            drop_req_q <= drop_req_d;
        end
    end

    assign drop_req_o        = drop_req_q;
    assign x_o               = 10'(INIT_X);
    assign y_o               = 9'(INIT_Y);
    assign state_o           = state_q;
    assign animation_state_o = anim_q;
    assign live_count_o      = live_q;

endmodule

`default_nettype wire

// File: doc/kong_ctrl.md
KONG_CTRL -- requirements
Module: kong_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, phase timer width; SHALL hold NORMAL_LEN+2^JITTER_W-1.
REQ-002 Parameter NORMAL_LEN, default 160, base NORMAL phase length in cycles (>=1).
REQ-003 Parameter GET_LEN, default 32, GET phase length in cycles (>=1).
REQ-004 Parameter HOLD_LEN, default 32, HOLD phase length in cycles (>=1).
REQ-005 Parameter JITTER_W, default 4, random extra NORMAL cycles 0..2^JITTER_W-1; 0 disables jitter.
REQ-006 Parameter MAX_LIVE, default 4, maximum barrels in flight (>=1).
REQ-007 Parameter INIT_X, default 127; INIT_Y, default 79; sprite position.
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst  in  1  reset, asynchronous and active-low.
REQ-010 start  in  1  level; begins play from IDLE.
REQ-011 over  in  1  level; game over, returns to IDLE.
REQ-012 pause  in  1  level; freezes animation while high.
REQ-013 drop_ack  in  1  barrel spawner accepted the current drop.
REQ-014 barrel_gone  in  1  one-cycle pulse; one barrel left the screen.
REQ-015 drop_req  out  1  registered; barrel drop request.
REQ-016 x  out  10  constant INIT_X.  y  out  9  constant INIT_Y.
REQ-017 state  out  2  top FSM: IDLE=00, PLAYING=01, PAUSED=10.
REQ-018 animation_state  out  2  NORMAL=00, GET=01, HOLD=10, DROP=11.
REQ-019 live_count  out  $clog2(MAX_LIVE+1)  barrels currently in flight.

Function
REQ-020 Top FSM SHALL be registered, one-cycle latency: IDLE->PLAYING on start; PLAYING->IDLE on over; PLAYING->PAUSED on pause; PAUSED->PLAYING on !pause; PAUSED->IDLE on over; over SHALL take priority over pause.
REQ-021 Animation SHALL advance only in PLAYING, sequence NORMAL->GET->HOLD->DROP->NORMAL.
REQ-022 On phase entry timer SHALL load LEN-1 and decrement each PLAYING cycle; phase exits at timer==0, so a phase lasts exactly LEN PLAYING cycles.
REQ-023 NORMAL length SHALL be NORMAL_LEN + lfsr[JITTER_W-1:0], sampled on NORMAL entry.
REQ-024 NORMAL->GET SHALL occur only when timer==0 and live_count<MAX_LIVE; otherwise stays NORMAL with timer held at 0.
REQ-025 In DROP, drop_req SHALL be 1; DROP persists until drop_ack==1 with drop_req==1, then next cycle NORMAL, drop_req 0, live_count+1.
REQ-026 barrel_gone SHALL decrement live_count in PLAYING and PAUSED; ignored at 0; ack and gone in the same cycle SHALL leave live_count unchanged.
REQ-027 In PAUSED, timer and animation_state SHALL hold, drop_req SHALL be 0, drop_ack SHALL be ignored; on resume drop_req reasserts if still in DROP.
REQ-028 Entering IDLE SHALL force animation_state NORMAL, drop_req 0, live_count 0, timer reload; IDLE holds these.
REQ-029 A 16-bit LFSR SHALL free-run in all states, seed 16'hACE1, never reaching zero.

Reset
REQ-030 rst low SHALL immediately set state IDLE, animation_state NORMAL, drop_req 0, live_count 0, timer 0, LFSR 16'hACE1; x/y unaffected constants.
REQ-031 Deassertion SHALL take effect at the next rising clk; start high during reset SHALL be ignored until then.

Structure
REQ-032 Package kong_pkg SHALL hold top-state and animation-state encodings and the LFSR seed constant.
REQ-033 One sub-module, lfsr16, SHALL provide the free-running random source.

Verification (NORMAL_LEN=4, GET_LEN=2, HOLD_LEN=2, JITTER_W=0, MAX_LIVE=2)
REQ-034 rst low -> state 00, anim 00, drop_req 0, live 0, x=127, y=79; release then start -> state 01 next edge.
REQ-035 Play: NORMAL 4, GET 2, HOLD 2 cycles, then DROP with drop_req=1; ack low 3 cycles -> DROP held; ack -> NORMAL next cycle, live 1.
REQ-036 Two drops, no gone -> live 2, anim stays 00 indefinitely; one barrel_gone -> live 1, GET next cycle.
REQ-037 ack+gone same cycle at live 1 -> live 1; gone at live 0 -> live 0.
REQ-038 pause 10 cycles entered after first HOLD cycle -> anim 10 frozen, drop_req 0; release -> exactly one more HOLD cycle, then DROP.
REQ-039 over in DROP -> state 00, drop_req 0, live 0 next edge; rst asserted between edges -> outputs reset without clock.
